// File: rtl/spi_master_engine_if.sv
// Host-side PIO bus bundle for the SPI page peripheral.
// The glue logic drives it as master and the engine responds as slave.
interface spi_master_engine_if;
   logic       chip_enable;
   logic       read_write_n;
   logic [1:0] host_address;
   logic [7:0] host_din;
   logic [7:0] host_qout;

   modport master (output chip_enable, read_write_n, host_address, host_din,
                   input  host_qout);
   modport slave  (input  chip_enable, read_write_n, host_address, host_din,
                   output host_qout);
endinterface

// File: rtl/spi_master_engine.sv
// Byte-wide, rate-programmable SPI master with a handshaked host register page.
// Handles one byte per transfer, MSB first, with a busy/done/overrun status and a level IRQ.
module spi_master_engine #(
   parameter int DIV_WIDTH = 7,
   parameter int RATE_MAX  = 6
) (
   input  logic                clock,
   input  logic                reset,
   spi_master_engine_if.slave  host,
   output logic                spi_sclk,
   output logic                spi_mosi,
   input  logic                spi_miso,
   output logic                busy,
   output logic                done_irq
);

   typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

   state_t               state, state_next;
   logic                 wr_req, wr_req_p0, wr_pulse_p1;
   logic [1:0]           wr_addr_p1;
   logic [7:0]           wr_data_p1;
   logic                 data_wr, ctrl_wr, clr_wr;
   logic [4:0]           ctrl;
   logic [7:0]           rx_byte, shift_reg;
   logic                 done, overrun;
   logic [2:0]           rate_l;
   logic                 cpol_l;
   logic                 miso_s;
   logic [4:0]           edge_cnt;
   logic [DIV_WIDTH-1:0] presc, half_m1;
   logic                 start, tick, finish;

   function automatic logic [2:0] clamp_rate(input logic [2:0] r);
      return (r > 3'(RATE_MAX)) ? 3'(RATE_MAX) : r;
   endfunction

   // Stage p0/p1: registered write-strobe edge detect with captured address/data
   assign wr_req = host.chip_enable & ~host.read_write_n;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_req_p0   <= 1'b0;
         wr_pulse_p1 <= 1'b0;
         wr_addr_p1  <= 2'd0;
         wr_data_p1  <= 8'h00;
      end else begin
         wr_req_p0   <= wr_req;
         wr_pulse_p1 <= wr_req & ~wr_req_p0;
         if (wr_req & ~wr_req_p0) begin
            wr_addr_p1 <= host.host_address;
            wr_data_p1 <= host.host_din;
         end
      end
   end

   assign data_wr = wr_pulse_p1 && (wr_addr_p1 == 2'd0);
   assign ctrl_wr = wr_pulse_p1 && (wr_addr_p1 == 2'd1);
   assign clr_wr  = wr_pulse_p1 && (wr_addr_p1 == 2'd3);
   assign half_m1 = DIV_WIDTH'((32'd1 << rate_l) - 32'd1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      tick       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (data_wr) begin
               start      = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (presc == half_m1) begin
               tick = 1'b1;
               if (edge_cnt == 5'd15) state_next = TAIL;
            end
         end
         TAIL: begin
            if (presc == half_m1) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ctrl      <= 5'd0;
         rx_byte   <= 8'h00;
         shift_reg <= 8'h00;
         done      <= 1'b0;
         overrun   <= 1'b0;
         rate_l    <= 3'd0;
         cpol_l    <= 1'b0;
         miso_s    <= 1'b0;
         edge_cnt  <= 5'd0;
         presc     <= '0;
         spi_sclk  <= 1'b0;
         spi_mosi  <= 1'b0;
      end else begin
         if (ctrl_wr) ctrl <= wr_data_p1[4:0];

         // A DATA write while not idle (including the final TAIL clock) is dropped
         if (data_wr && state != IDLE) overrun <= 1'b1;
         else if (clr_wr)              overrun <= 1'b0;

         if (finish)      done <= 1'b1;
         else if (clr_wr) done <= 1'b0;

         case (state)
            IDLE: begin
               spi_sclk <= ctrl[3];
               if (start) begin
                  shift_reg <= wr_data_p1;
                  edge_cnt  <= 5'd0;
                  presc     <= '0;
                  rate_l    <= clamp_rate(ctrl[2:0]);
                  cpol_l    <= ctrl[3];
                  spi_mosi  <= wr_data_p1[7];
               end
            end
            SHIFT: begin
               if (tick) begin
                  presc    <= '0;
                  edge_cnt <= edge_cnt + 5'd1;
                  if (!edge_cnt[0]) begin
                     miso_s   <= spi_miso;
                     spi_sclk <= ~spi_sclk;
                  end else begin
                     shift_reg <= {shift_reg[6:0], miso_s};
                     if (edge_cnt == 5'd15) begin
                        spi_sclk <= cpol_l;
                     end else begin
                        spi_sclk <= ~spi_sclk;
                        spi_mosi <= shift_reg[6];
                     end
                  end
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            TAIL: begin
               if (finish) rx_byte <= shift_reg;
               else        presc   <= presc + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy     = (state != IDLE);
   assign done_irq = done & ctrl[4];

   always_comb begin
      host.host_qout = 8'h00;
      case (host.host_address)
         2'd0:    host.host_qout = rx_byte;
         2'd1:    host.host_qout = {3'b000, ctrl};
         2'd2:    host.host_qout = {5'b00000, overrun, done, busy};
         default: host.host_qout = 8'h00;
      endcase
   end

endmodule
